// File: rtl/serial_adder_sched_if.sv
// Operand/result bundle for serial_adder_sched: two requester ports and one result port.
interface serial_adder_sched_if #(
  parameter int WIDTH = 8
) ();
  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in0_a;
  logic [WIDTH-1:0] in0_b;
  logic             in0_cin;
  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] in1_a;
  logic [WIDTH-1:0] in1_b;
  logic             in1_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_id;

  modport master (
    output in0_valid, in0_a, in0_b, in0_cin,
    output in1_valid, in1_a, in1_b, in1_cin,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_sum, out_cout, out_id
  );

  modport slave (
    input  in0_valid, in0_a, in0_b, in0_cin,
    input  in1_valid, in1_a, in1_b, in1_cin,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_sum, out_cout, out_id
  );
endinterface

// File: rtl/serial_adder_sched.sv
// Round-robin scheduler feeding two requesters through one shared 1-bit full-adder
// slice, LSB first, one bit per clock, result tagged with the requester id.
module serial_adder_sched #(
  parameter int WIDTH  = 8,
  parameter int CIN_EN = 1
) (
  input logic                clk,
  input logic                rst_n,
  serial_adder_sched_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } req_t;

  state_t           state, state_nxt;
  req_t [1:0]       req;
  logic [1:0]       vld, rdy;
  logic             grant, last_grant, acc;
  logic [WIDTH-1:0] a_r, b_r, sum_r, sum_nxt;
  logic [WIDTH-1:0] out_sum_r;
  logic             carry, c_nxt, s, out_cout_r, out_id_r, last_bit;
  logic [CW-1:0]    cnt;

  assign vld    = {bus.in1_valid, bus.in0_valid};
  assign req[0] = '{a: bus.in0_a, b: bus.in0_b, cin: bus.in0_cin};
  assign req[1] = '{a: bus.in1_a, b: bus.in1_b, cin: bus.in1_cin};

  // Contended cycles go to whoever did not win last; lone requesters win outright.
  always_comb begin
    grant = vld[1];
    if (&vld) grant = ~last_grant;
  end

  // Gated by rst_n so neither port can appear ready while reset is held.
  assign rdy[0] = rst_n & (state == IDLE) & ~grant & vld[0];
  assign rdy[1] = rst_n & (state == IDLE) &  grant & vld[1];
  assign acc    = |(vld & rdy);

  assign bus.in0_ready = rdy[0];
  assign bus.in1_ready = rdy[1];

  assign s        = a_r[0] ^ b_r[0] ^ carry;
  assign c_nxt    = (a_r[0] & b_r[0]) | (a_r[0] & carry) | (b_r[0] & carry);
  assign sum_nxt  = (sum_r >> 1) | (WIDTH'(s) << (WIDTH - 1));
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      carry      <= 1'b0;
      cnt        <= '0;
      last_grant <= 1'b1;
      out_id_r   <= 1'b0;
      out_sum_r  <= '0;
      out_cout_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          a_r        <= req[grant].a;
          b_r        <= req[grant].b;
          carry      <= (CIN_EN != 0) & req[grant].cin;
          cnt        <= '0;
          out_id_r   <= grant;
          last_grant <= grant;
        end
        RUN: begin
          a_r   <= a_r >> 1;
          b_r   <= b_r >> 1;
          sum_r <= sum_nxt;
          carry <= c_nxt;
          cnt   <= cnt + CW'(1);
          // Result registers are separate so they hold across the next op's RUN.
          if (last_bit) begin
            out_sum_r  <= sum_nxt;
            out_cout_r <= c_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = (state == DONE);
  assign bus.out_sum   = out_sum_r;
  assign bus.out_cout  = out_cout_r;
  assign bus.out_id    = out_id_r;
endmodule
